// File: rtl/gfm_sel_ctrl_if.sv
// gfm_sel_ctrl_if: request handshake and status bundle for the clock-select controller
interface gfm_sel_ctrl_if;
  logic req_valid, req_sel, req_ready, select, busy, done, err, fail, clk2_ok;
  modport master(output req_valid, req_sel, input req_ready, select, busy, done, err, fail, clk2_ok);
  modport slave(input req_valid, req_sel, output req_ready, select, busy, done, err, fail, clk2_ok);
endinterface

// File: rtl/gfm_sel_ctrl.sv
// gfm_sel_ctrl: clk2-aware select controller for a glitch-free 2:1 clock mux
module gfm_sel_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_LOG2 = 3,
  parameter int MON_WINDOW = 64,
  parameter int MIN_EDGES = 2,
  parameter int SETTLE_CYCLES = 8
)(
  input logic clk1,
  input logic rstn,
  input logic clk2,
  gfm_sel_ctrl_if.slave bus
);
  localparam int WW = $clog2(MON_WINDOW);
  localparam int EW = $clog2(MIN_EDGES + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [0:0] IDLE = 1'b0, SETTLE = 1'b1;
  logic [DIV_LOG2-1:0] div;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_q, tog, ok_q, fail_cond, win_end;
  logic [WW-1:0] win;
  logic [EW-1:0] edges, edges_nxt;
  logic [CW-1:0] cnt;
  logic [0:0] state;
  always_ff @(posedge clk2 or negedge rstn)
    if (!rstn) div <= '0;
    else div <= div + DIV_LOG2'(1);
  assign tog = sync[SYNC_STAGES-1] ^ sync_q;
  assign win_end = win == WW'(MON_WINDOW - 1);
  assign edges_nxt = (tog && edges != EW'(MIN_EDGES)) ? edges + EW'(1) : edges;
  assign fail_cond = !bus.select && ok_q && !bus.clk2_ok;
  assign bus.req_ready = state == IDLE && !fail_cond;
  assign bus.busy = state == SETTLE;
  // prescaler MSB is the only signal crossing from clk2; it toggles slowly enough to sample
  always_ff @(posedge clk1 or negedge rstn)
    if (!rstn) begin
      sync <= '0;
      sync_q <= 1'b0;
      win <= '0;
      edges <= '0;
      ok_q <= 1'b0;
      bus.clk2_ok <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], div[DIV_LOG2-1]};
      sync_q <= sync[SYNC_STAGES-1];
      ok_q <= bus.clk2_ok;
      win <= win_end ? '0 : win + WW'(1);
      edges <= win_end ? '0 : edges_nxt;
      if (win_end) bus.clk2_ok <= edges_nxt == EW'(MIN_EDGES);
    end
  always_ff @(posedge clk1 or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      bus.select <= 1'b1;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.fail <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.fail <= 1'b0;
      if (fail_cond) begin
        bus.select <= 1'b1;
        bus.fail <= 1'b1;
        state <= SETTLE;
        cnt <= CW'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE) begin
        if (cnt == '0) begin
          state <= IDLE;
          bus.done <= 1'b1;
        end else cnt <= cnt - CW'(1);
      end else if (bus.req_valid) begin
        if (bus.req_sel == bus.select) bus.done <= 1'b1;
        else if (!bus.req_sel && !bus.clk2_ok) bus.err <= 1'b1;
        else begin
          bus.select <= bus.req_sel;
          state <= SETTLE;
          cnt <= CW'(SETTLE_CYCLES - 1);
        end
      end
    end
endmodule

// File: tb/tb_gfm_sel_ctrl.sv
// tb_gfm_sel_ctrl: randomized requests and clk2 start/stop checked against a cycle model
module tb_gfm_sel_ctrl;
  localparam int SYNC = 2, DIV = 3, MON = 64, MINE = 2, SETTLE = 8;
  logic clk1 = 1'b0, clk2 = 1'b0, rstn = 1'b1, c2_en = 1'b1;
  int c2_half = 15000;
  int n_vec = 0, n_err = 0;
  gfm_sel_ctrl_if bus();
  gfm_sel_ctrl #(.SYNC_STAGES(SYNC), .DIV_LOG2(DIV), .MON_WINDOW(MON), .MIN_EDGES(MINE),
    .SETTLE_CYCLES(SETTLE)) dut (.clk1(clk1), .rstn(rstn), .clk2(clk2), .bus(bus));
  // clk1 edges land on even time steps, clk2 edges on odd ones, so they never coincide
  always #5000 clk1 = ~clk1;
  initial begin
    #1001;
    forever begin
      if (c2_en) clk2 = ~clk2;
      #(c2_half);
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [DIV-1:0] m_div;
  always @(posedge clk2 or negedge rstn)
    if (!rstn) m_div <= '0;
    else m_div <= m_div + 1'b1;
  int m_win, m_cnt, m_left;
  logic m_ok, m_okp, m_sel, m_done, m_err, m_fail;
  logic q[$];
  always @(posedge clk1 or negedge rstn) begin : model
    logic fc, t;
    if (!rstn) begin
      m_win = 0; m_cnt = 0; m_left = 0;
      m_ok = 0; m_okp = 0; m_sel = 1; m_done = 0; m_err = 0; m_fail = 0;
      q.delete();
      repeat (SYNC + 1) q.push_back(1'b0);
    end else begin
      fc = !m_sel && m_okp && !m_ok;
      m_done = 0; m_err = 0; m_fail = 0;
      if (fc) begin
        m_sel = 1; m_fail = 1; m_left = SETTLE;
      end else if (m_left > 0) begin
        m_left--;
        m_done = m_left == 0;
      end else if (bus.req_valid) begin
        if (bus.req_sel == m_sel) m_done = 1;
        else if (!bus.req_sel && !m_ok) m_err = 1;
        else begin
          m_sel = bus.req_sel; m_left = SETTLE;
        end
      end
      t = q[0] ^ q[1];
      void'(q.pop_front());
      q.push_back(m_div[DIV-1]);
      m_cnt += int'(t);
      m_okp = m_ok;
      if (m_win == MON - 1) begin
        m_ok = m_cnt >= MINE; m_cnt = 0; m_win = 0;
      end else m_win++;
    end
  end
  always @(negedge clk1) begin
    check("select", 32'(bus.select), 32'(m_sel));
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    check("done", 32'(bus.done), 32'(m_done));
    check("err", 32'(bus.err), 32'(m_err));
    check("fail", 32'(bus.fail), 32'(m_fail));
    check("clk2_ok", 32'(bus.clk2_ok), 32'(m_ok));
    check("req_ready", 32'(bus.req_ready), 32'(m_left == 0 && !(!m_sel && m_okp && !m_ok)));
  end
  task automatic rnd(int n, int pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk1);
      bus.req_valid = $urandom_range(99) < pct;
      bus.req_sel = 1'($urandom_range(1));
    end
  endtask
  initial begin
    int lat, lows;
    bit seen;
    bus.req_valid = 1'b0;
    bus.req_sel = 1'b1;
    #1000 rstn = 1'b0;
    repeat (3) @(negedge clk1);
    rstn = 1'b1;
    repeat (10) @(negedge clk1);
    bus.req_valid = 1'b1; bus.req_sel = 1'b0;
    @(negedge clk1);
    bus.req_valid = 1'b0;
    check("early_err", 32'(bus.err), 1);
    check("early_sel", 32'(bus.select), 1);
    rnd(400, 30);
    for (int i = 0; i < 300 && !(bus.select == 1'b0 && !bus.busy); i++) begin
      bus.req_valid = 1'b1; bus.req_sel = 1'b0;
      @(negedge clk1);
    end
    check("to_clk2", 32'(bus.select), 0);
    c2_en = 1'b0;
    seen = 0; lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk1);
      if (bus.fail) begin
        seen = 1; lat = i;
      end
    end
    check("fail_seen", 32'(seen), 1);
    check("fail_lat", 32'(lat >= 0 && lat <= 2 * MON + SYNC + 3), 1);
    rnd(20, 100);
    check("dead_ok", 32'(bus.clk2_ok), 0);
    c2_en = 1'b1;
    rnd(150, 0);
    for (int i = 0; i < 50 && !bus.busy; i++) begin
      bus.req_valid = 1'b1; bus.req_sel = ~bus.select;
      @(negedge clk1);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk1);
    #2000 rstn = 1'b0;
    #1000;
    check("rst_sel", 32'(bus.select), 1);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk1);
    rstn = 1'b1;
    rnd(300, 30);
    c2_half = 1280;
    lows = 0;
    for (int i = 0; i < 1400; i++) begin
      rnd(1, 20);
      if (i >= 200 && !bus.clk2_ok) lows++;
    end
    check("fast_ok_lows", 32'(lows), 0);
    bus.req_valid = 1'b0;
    @(negedge clk1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
